// File: rtl/pager_pkg.sv
// Shared pager definitions: fail codes, sweep FSM encoding and page-table entry layout.
// The entry carries an extra even-parity bit when PAGER_PARITY_EN is defined.
package pager_pkg;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_INVALID = 2'd1;
  localparam logic [1:0] FAIL_WPROT   = 2'd2;
  localparam logic [1:0] FAIL_USER    = 2'd3;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  // Flag bit offsets, counted upward from the top of the PPN field.
  localparam int unsigned OFF_USER      = 0;
  localparam int unsigned OFF_CACHEABLE = 1;
  localparam int unsigned OFF_WRITEABLE = 2;
  localparam int unsigned OFF_VALID     = 3;
  localparam int unsigned OFF_PARITY    = 4;
  localparam int unsigned NUM_FLAGS     = 4;

`ifdef PAGER_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  function automatic int unsigned entry_width(input int unsigned ppn_width);
    return ppn_width + NUM_FLAGS + PARITY_BITS;
  endfunction

endpackage

// File: rtl/pager_ram.sv
// Single-port write-first page-table RAM; the read register only updates on a read request
// so the last lookup result holds. Kept separate so it can be retargeted per FPGA family.
module pager_ram #(
  parameter int unsigned AddrWidth = 9,
  parameter int unsigned DataWidth = 15
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem [2**AddrWidth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= we_i ? wdata_i : mem[addr_i];
    end
  end

endmodule

// File: rtl/pager.sv
// KS-10 page translation unit with a hardware invalidation sweep after reset and on request.
// Define PAGER_PARITY_EN to store and check an even-parity bit per entry.
module pager
  import pager_pkg::*;
#(
  parameter int unsigned VPN_WIDTH  = 9,
  parameter int unsigned PPN_WIDTH  = 11,
  parameter int unsigned WORD_WIDTH = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clken,
  input  logic                            vma_en,
  input  logic [VPN_WIDTH+WORD_WIDTH-1:0] vaddr,
  input  logic                            acc_user,
  input  logic                            acc_write,
  input  logic                            pt_write,
  input  logic                            wr_valid,
  input  logic                            wr_writeable,
  input  logic                            wr_cacheable,
  input  logic                            wr_user,
  input  logic [PPN_WIDTH-1:0]            wr_ppn,
  input  logic                            sweep,
  output logic                            sweep_busy,
  output logic [PPN_WIDTH+WORD_WIDTH-1:0] paddr,
  output logic                            cacheable,
  output logic                            page_fail,
  output logic [1:0]                      fail_code,
  output logic                            parity_err
);

  localparam int unsigned EntryWidth = entry_width(PPN_WIDTH);
  localparam logic [VPN_WIDTH-1:0] LastVpn = '1;

  logic [0:0]            state_q, state_d;
  logic [VPN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] word_q;
  logic                  acc_user_q, acc_write_q, res_valid_q;

  logic                  busy, lookup, ram_we, perr;
  logic [VPN_WIDTH-1:0]  vpn, ram_addr;
  logic [EntryWidth-1:0] wr_entry, ram_wdata, ram_rdata;

  assign busy       = (state_q == StSweep);
  assign sweep_busy = busy;
  assign vpn        = vaddr[VPN_WIDTH+WORD_WIDTH-1 -: VPN_WIDTH];
  assign lookup     = clken & vma_en & ~busy;
  assign ram_we     = clken & (busy | pt_write);
  assign ram_addr   = busy ? cnt_q : vpn;
  assign ram_wdata  = busy ? '0 : wr_entry;

  always_comb begin
    wr_entry                            = '0;
    wr_entry[PPN_WIDTH-1:0]             = wr_ppn;
    wr_entry[PPN_WIDTH+OFF_USER]        = wr_user;
    wr_entry[PPN_WIDTH+OFF_CACHEABLE]   = wr_cacheable;
    wr_entry[PPN_WIDTH+OFF_WRITEABLE]   = wr_writeable;
    wr_entry[PPN_WIDTH+OFF_VALID]       = wr_valid;
`ifdef PAGER_PARITY_EN
    wr_entry[PPN_WIDTH+OFF_PARITY]      = ^{wr_valid, wr_writeable, wr_cacheable, wr_user, wr_ppn};
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StSweep) begin
      cnt_d = cnt_q + VPN_WIDTH'(1);
      if (cnt_q == LastVpn) begin
        state_d = StIdle;
      end
    end else if (sweep) begin
      state_d = StSweep;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StSweep;
      cnt_q       <= '0;
      word_q      <= '0;
      acc_user_q  <= 1'b0;
      acc_write_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lookup) begin
        word_q      <= vaddr[WORD_WIDTH-1:0];
        acc_user_q  <= acc_user;
        acc_write_q <= acc_write;
        res_valid_q <= 1'b1;
      end
    end
  end

  pager_ram #(
    .AddrWidth(VPN_WIDTH),
    .DataWidth(EntryWidth)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .re_i   (lookup),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

`ifdef PAGER_PARITY_EN
  // Even parity over the whole stored word, parity bit included, must be zero.
  assign perr = res_valid_q & (^ram_rdata);
`else
  assign perr = 1'b0;
`endif

  // Before the first lookup the RAM read register is undefined, so report "no translation".
  always_comb begin
    paddr     = '0;
    cacheable = 1'b0;
    fail_code = FAIL_INVALID;
    if (res_valid_q) begin
      paddr     = {ram_rdata[PPN_WIDTH-1:0], word_q};
      cacheable = ram_rdata[PPN_WIDTH+OFF_CACHEABLE];
      if (!ram_rdata[PPN_WIDTH+OFF_VALID] || perr) begin
        fail_code = FAIL_INVALID;
      end else if (acc_write_q && !ram_rdata[PPN_WIDTH+OFF_WRITEABLE]) begin
        fail_code = FAIL_WPROT;
      end else if (acc_user_q && !ram_rdata[PPN_WIDTH+OFF_USER]) begin
        fail_code = FAIL_USER;
      end else begin
        fail_code = FAIL_NONE;
      end
    end
  end

  assign page_fail  = (fail_code != FAIL_NONE);
  assign parity_err = perr;

endmodule

// File: tb/tb_pager.sv
// Self-checking bench for pager: vector table plus sweep/reset sequences, scoreboard-checked.
module tb_pager;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b1;
  logic        vma_en = 1'b0;
  logic [17:0] vaddr = '0;
  logic        acc_user = 1'b0, acc_write = 1'b0, pt_write = 1'b0;
  logic        wr_valid = 1'b0, wr_writeable = 1'b0, wr_cacheable = 1'b0, wr_user = 1'b0;
  logic [10:0] wr_ppn = '0;
  logic        sweep = 1'b0;
  logic        sweep_busy, cacheable, page_fail, parity_err;
  logic [19:0] paddr;
  logic [1:0]  fail_code;

  always #5 clk = ~clk;

  pager #(
    .VPN_WIDTH (9),
    .PPN_WIDTH (11),
    .WORD_WIDTH(9)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clken       (clken),
    .vma_en      (vma_en),
    .vaddr       (vaddr),
    .acc_user    (acc_user),
    .acc_write   (acc_write),
    .pt_write    (pt_write),
    .wr_valid    (wr_valid),
    .wr_writeable(wr_writeable),
    .wr_cacheable(wr_cacheable),
    .wr_user     (wr_user),
    .wr_ppn      (wr_ppn),
    .sweep       (sweep),
    .sweep_busy  (sweep_busy),
    .paddr       (paddr),
    .cacheable   (cacheable),
    .page_fail   (page_fail),
    .fail_code   (fail_code),
    .parity_err  (parity_err)
  );

  typedef struct packed {
    logic [19:0] paddr;
    logic        cacheable;
    logic [1:0]  code;
    logic        perr;
  } res_t;

  typedef struct {
    bit          pt;
    bit          vma;
    logic [8:0]  vpn;
    logic [8:0]  word;
    logic [3:0]  flags;  // {valid, writeable, cacheable, user}
    logic [10:0] ppn;
    bit          au;
    bit          aw;
    int          code;
  } vec_t;

  res_t        exp_q[$];
  res_t        last;
  logic [14:0] m_mem[512];  // {valid, writeable, cacheable, user, ppn}
  bit          m_busy = 1'b0;
  int unsigned m_cnt = 0;
  int          n_vec = 0, n_fail = 0;
  string       tag = "init";
  vec_t        vt[13];
  int          n, frz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, want 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic check_out(input res_t e);
    check("paddr", 32'(paddr), 32'(e.paddr));
    check("cacheable", 32'(cacheable), 32'(e.cacheable));
    check("fail_code", 32'(fail_code), 32'(e.code));
    check("page_fail", 32'(page_fail), 32'(e.code != 2'd0));
    check("parity_err", 32'(parity_err), 32'(e.perr));
  endtask

  task automatic reset_checks();
    check("rst_paddr", 32'(paddr), 32'h0);
    check("rst_cacheable", 32'(cacheable), 32'h0);
    check("rst_busy", 32'(sweep_busy), 32'h1);
    check("rst_page_fail", 32'(page_fail), 32'h1);
    check("rst_fail_code", 32'(fail_code), 32'h1);
    check("rst_parity_err", 32'(parity_err), 32'h0);
  endtask

  // Advance one clock; the model applies the same cycle and queues any accepted lookup result.
  // want_code < 0 takes the fail code from the model, otherwise the caller's hand-derived code.
  task automatic tick(input int want_code, input bit want_perr);
    res_t        e;
    logic [14:0] ent;
    logic [8:0]  v;
    bit          acc;
    acc = clken && !m_busy;
    v   = vaddr[17:9];
    if (acc && pt_write) m_mem[v] = {wr_valid, wr_writeable, wr_cacheable, wr_user, wr_ppn};
    if (acc && vma_en) begin
      ent         = m_mem[v];
      e.paddr     = {ent[10:0], vaddr[8:0]};
      e.cacheable = ent[12];
      if (!ent[14]) e.code = 2'd1;
      else if (acc_write && !ent[13]) e.code = 2'd2;
      else if (acc_user && !ent[11]) e.code = 2'd3;
      else e.code = 2'd0;
      if (want_code >= 0) e.code = want_code[1:0];
      e.perr = want_perr;
      exp_q.push_back(e);
    end
    if (clken && m_busy) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 511) m_busy = 1'b0;
      m_cnt = (m_cnt + 1) % 512;
    end else if (clken && sweep) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      last = e;
      check_out(e);
    end
  endtask

  task automatic idle_inputs();
    vma_en = 1'b0; pt_write = 1'b0; sweep = 1'b0; acc_user = 1'b0; acc_write = 1'b0;
    {wr_valid, wr_writeable, wr_cacheable, wr_user} = 4'h0;
    wr_ppn = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    pt_write  = v.pt;
    vma_en    = v.vma;
    vaddr     = {v.vpn, v.word};
    {wr_valid, wr_writeable, wr_cacheable, wr_user} = v.flags;
    wr_ppn    = v.ppn;
    acc_user  = v.au;
    acc_write = v.aw;
    tick(v.vma ? v.code : -1, 1'b0);
    idle_inputs();
  endtask

  function automatic vec_t mk(input bit pt, input bit vma, input logic [8:0] vpn,
                              input logic [8:0] word, input logic [3:0] flags,
                              input logic [10:0] ppn, input bit au, input bit aw, input int code);
    vec_t v;
    v.pt = pt; v.vma = vma; v.vpn = vpn; v.word = word; v.flags = flags;
    v.ppn = ppn; v.au = au; v.aw = aw; v.code = code;
    return v;
  endfunction

  // Count clken cycles until sweep_busy drops, bounded.
  task automatic run_sweep_to_end(output int cnt);
    cnt = 0;
    for (int g = 0; g < 3000; g++) begin
      if (!sweep_busy) break;
      tick(-1, 1'b0);
      cnt++;
    end
  endtask

  initial begin
    vt[0]  = mk(0, 1, 9'h1FF, 9'h000, 4'b0000, 11'h000, 0, 0, 1);
    vt[1]  = mk(1, 0, 9'h023, 9'h000, 4'b1111, 11'h5A1, 0, 0, -1);
    vt[2]  = mk(0, 1, 9'h023, 9'h077, 4'b0000, 11'h000, 0, 0, 0);
    vt[3]  = mk(1, 0, 9'h040, 9'h000, 4'b1001, 11'h123, 0, 0, -1);
    vt[4]  = mk(0, 1, 9'h040, 9'h005, 4'b0000, 11'h000, 0, 1, 2);
    vt[5]  = mk(1, 0, 9'h041, 9'h000, 4'b1110, 11'h7FF, 0, 0, -1);
    vt[6]  = mk(0, 1, 9'h041, 9'h1FF, 4'b0000, 11'h000, 1, 0, 3);
    vt[7]  = mk(0, 1, 9'h041, 9'h000, 4'b0000, 11'h000, 0, 1, 0);
    vt[8]  = mk(1, 0, 9'h042, 9'h000, 4'b0010, 11'h0AA, 0, 0, -1);
    vt[9]  = mk(0, 1, 9'h042, 9'h011, 4'b0000, 11'h000, 1, 1, 1);
    vt[10] = mk(1, 1, 9'h050, 9'h0C3, 4'b1111, 11'h333, 1, 1, 0);
    vt[11] = mk(0, 1, 9'h040, 9'h000, 4'b0000, 11'h000, 1, 0, 0);
    vt[12] = mk(0, 1, 9'h023, 9'h100, 4'b0000, 11'h000, 1, 1, 0);

    // Power-on reset and automatic sweep.
    tag = "reset";
    #2 rst = 1'b0;
    m_busy = 1'b1;
    m_cnt  = 0;
    @(negedge clk);
    reset_checks();
    @(negedge clk);
    rst = 1'b1;
    run_sweep_to_end(n);
    check("reset_sweep_len", 32'(n), 32'd512);

    tag = "vec";
    for (int i = 0; i < 13; i++) begin
      apply_vec(vt[i]);
      if (i == 2) check("paddr_5a1_077", 32'(paddr), 32'({11'h5A1, 9'h077}));
    end
    tag = "hold";
    tick(-1, 1'b0);
    tick(-1, 1'b0);
    check_out(last);

    // Requested sweep with a clken freeze and ignored requests mid-sweep.
    tag = "sweep";
    sweep = 1'b1;
    tick(-1, 1'b0);
    sweep = 1'b0;
    check("sweep_start", 32'(sweep_busy), 32'h1);
    n = 0;
    frz = 0;
    for (int g = 0; g < 3000; g++) begin
      if (!sweep_busy) break;
      clken = 1'b1;
      if (n == 100 && frz < 10) begin
        clken = 1'b0;
        frz++;
      end
      if (n == 50) begin
        vma_en = 1'b1; vaddr = {9'h023, 9'h001}; acc_user = 1'b1;
      end
      if (n == 300) begin
        pt_write = 1'b1; vaddr = {9'h060, 9'h000};
        {wr_valid, wr_writeable, wr_cacheable, wr_user} = 4'hF; wr_ppn = 11'h246;
      end
      if (n == 400) sweep = 1'b1;
      tick(-1, 1'b0);
      if (clken) n++;
      else if (frz == 10) check("freeze_busy", 32'(sweep_busy), 32'h1);
      idle_inputs();
    end
    clken = 1'b1;
    check("sweep_len", 32'(n), 32'd512);
    check_out(last);
    apply_vec(mk(0, 1, 9'h023, 9'h077, 4'b0000, 11'h000, 0, 0, 1));
    apply_vec(mk(0, 1, 9'h060, 9'h000, 4'b0000, 11'h000, 0, 0, 1));

    // Reset at sweep counter 200 restarts a full sweep.
    tag = "midrst";
    apply_vec(mk(1, 0, 9'h0F0, 9'h000, 4'b1111, 11'h0F0, 0, 0, -1));
    sweep = 1'b1;
    tick(-1, 1'b0);
    sweep = 1'b0;
    for (int g = 0; g < 200; g++) tick(-1, 1'b0);
    rst = 1'b0;
    m_busy = 1'b1;
    m_cnt  = 0;
    exp_q.delete();
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b1;
    run_sweep_to_end(n);
    check("restart_sweep_len", 32'(n), 32'd512);
    apply_vec(mk(0, 1, 9'h0F0, 9'h003, 4'b0000, 11'h000, 0, 0, 1));

`ifdef PAGER_PARITY_EN
    tag = "parity";
    apply_vec(mk(1, 0, 9'h070, 9'h000, 4'b1111, 11'h155, 0, 0, -1));
    dut.u_ram.mem[9'h070][13] = ~dut.u_ram.mem[9'h070][13];
    vma_en = 1'b1;
    vaddr  = {9'h070, 9'h002};
    tick(1, 1'b1);
    idle_inputs();
    apply_vec(mk(1, 1, 9'h071, 9'h004, 4'b1111, 11'h156, 0, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
